// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Size/state enums, bus command payload, byte-enable and load-extract functions.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  // Offset must already be aligned for the size; reserved size behaves as word.
  function automatic logic [BE_W-1:0] gen_be(size_e sz, logic [1:0] off);
    logic [BE_W-1:0] be;
    case (sz)
      SZ_BYTE: be = BE_W'(4'b0001 << off);
      SZ_HALF: be = BE_W'(4'b0011 << off);
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] gen_wdata(size_e sz, logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(size_e sz, logic [1:0] off, logic uns,
                                                   logic [XLEN-1:0] d);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (sz)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  import lsu_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store-data replication, load extraction/extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e           i_size,
  input  logic [1:0]      i_off,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [BE_W-1:0] o_be_c,
  output logic [XLEN-1:0] o_wdata_c,
  output logic [XLEN-1:0] o_rdata_c
);

  assign o_be_c    = gen_be(i_size, i_off);
  assign o_wdata_c = gen_wdata(i_size, i_wdata);
  assign o_rdata_c = load_extract(i_size, i_off, i_unsigned, i_rdata);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: IDLE -> BUS -> RESP, req/ack memory handshake with timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned or reserved-size requests fault without a bus cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_resp_valid,
  output logic [XLEN-1:0]   o_resp_rdata,
  output logic              o_resp_fault,
  load_store_unit_if.master mem
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          r_state, w_state_nxt;
  logic            r_ready, w_ready_nxt;
  logic            r_mem_req, w_mem_req_nxt;
  mem_cmd_t        r_cmd, w_cmd_nxt;
  size_e           r_size, w_size_nxt;
  logic [1:0]      r_off, w_off_nxt;
  logic            r_uns, w_uns_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_cap_rdata, w_cap_rdata_nxt;
  logic            r_cap_fault, w_cap_fault_nxt;
  logic            r_resp_valid, w_resp_valid_nxt;
  logic [XLEN-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic            r_resp_fault, w_resp_fault_nxt;

  size_e           w_in_size, w_eff_size, w_al_size;
  logic [1:0]      w_eff_off, w_al_off;
  logic            w_al_uns;
  logic            w_reject, w_accept, w_timeout, w_ack;
  logic [BE_W-1:0] w_be_c;
  logic [XLEN-1:0] w_wdata_c, w_rdata_c;

  assign w_in_size = size_e'(i_req_size);
  assign w_accept  = r_ready && (r_state == ST_IDLE) && i_req_valid;
  assign w_ack     = mem.mem_ack;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Request qualification: reject (trap build) or force alignment (default build).
`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_eff_size = w_in_size;
    w_eff_off  = i_req_addr[1:0];
    w_reject   = (w_in_size == SZ_RSVD)
              || ((w_in_size == SZ_HALF) && i_req_addr[0])
              || ((w_in_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
  end
`else
  always_comb begin
    w_reject   = 1'b0;
    w_eff_size = (w_in_size == SZ_RSVD) ? SZ_WORD : w_in_size;
    w_eff_off  = i_req_addr[1:0];
    if (w_eff_size == SZ_HALF) w_eff_off = {i_req_addr[1], 1'b0};
    else if (w_eff_size == SZ_WORD) w_eff_off = 2'b00;
  end
`endif

  // Lane steering uses the incoming request in IDLE and the captured one afterwards.
  assign w_al_size = (r_state == ST_IDLE) ? w_eff_size     : r_size;
  assign w_al_off  = (r_state == ST_IDLE) ? w_eff_off      : r_off;
  assign w_al_uns  = (r_state == ST_IDLE) ? i_req_unsigned : r_uns;

  lsu_lane_align u_lane_align (
    .i_size     (w_al_size),
    .i_off      (w_al_off),
    .i_unsigned (w_al_uns),
    .i_wdata    (i_req_wdata),
    .i_rdata    (mem.mem_rdata),
    .o_be_c     (w_be_c),
    .o_wdata_c  (w_wdata_c),
    .o_rdata_c  (w_rdata_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_reject ? ST_RESP : ST_BUS;
      ST_BUS:  if (w_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for all registered outputs and request/capture registers.
  always_comb begin
    w_ready_nxt      = (w_state_nxt == ST_IDLE);
    w_mem_req_nxt    = (w_state_nxt == ST_BUS);
    w_cmd_nxt        = r_cmd;
    w_size_nxt       = r_size;
    w_off_nxt        = r_off;
    w_uns_nxt        = r_uns;
    w_cnt_nxt        = r_cnt;
    w_cap_rdata_nxt  = r_cap_rdata;
    w_cap_fault_nxt  = r_cap_fault;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_fault_nxt = r_resp_fault;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_size_nxt      = w_eff_size;
          w_off_nxt       = w_eff_off;
          w_uns_nxt       = i_req_unsigned;
          w_cnt_nxt       = '0;
          w_cap_rdata_nxt = '0;
          w_cap_fault_nxt = w_reject;
          if (!w_reject) begin
            w_cmd_nxt.we    = i_req_we;
            w_cmd_nxt.addr  = {i_req_addr[XLEN-1:2], 2'b00};
            w_cmd_nxt.be    = w_be_c;
            w_cmd_nxt.wdata = w_wdata_c;
          end
        end
      end
      ST_BUS: begin
        if (w_ack) begin
          w_cap_rdata_nxt = r_cmd.we ? '0 : w_rdata_c;
          w_cap_fault_nxt = 1'b0;
        end else if (w_timeout) begin
          w_cap_rdata_nxt = '0;
          w_cap_fault_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = r_cap_rdata;
        w_resp_fault_nxt = r_cap_fault;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_cmd        <= '0;
      r_size       <= SZ_BYTE;
      r_off        <= 2'b00;
      r_uns        <= 1'b0;
      r_cnt        <= '0;
      r_cap_rdata  <= '0;
      r_cap_fault  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      r_ready      <= w_ready_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_cmd        <= w_cmd_nxt;
      r_size       <= w_size_nxt;
      r_off        <= w_off_nxt;
      r_uns        <= w_uns_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cap_rdata  <= w_cap_rdata_nxt;
      r_cap_fault  <= w_cap_fault_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_fault <= w_resp_fault_nxt;
    end
  end

  assign o_req_ready   = r_ready;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_rdata  = r_resp_rdata;
  assign o_resp_fault  = r_resp_fault;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_cmd.we;
  assign mem.mem_addr  = r_cmd.addr;
  assign mem.mem_be    = r_cmd.be;
  assign mem.mem_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (TIMEOUT=4); honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        rej;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_fault;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_fault;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_resp_valid   (o_resp_valid),
    .o_resp_rdata   (o_resp_rdata),
    .o_resp_fault   (o_resp_fault),
    .mem            (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int delay,
                              logic [31:0] e_addr, logic [3:0] e_be, logic [31:0] e_wdata,
                              logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.delay = delay; v.rej = 1'b0; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_fault = 1'b0;
    return v;
  endfunction

  task automatic send_req(input vec_t v);
    i_req_valid = 1'b1; i_req_we = v.we; i_req_size = v.size; i_req_unsigned = v.uns;
    i_req_addr = v.addr; i_req_wdata = v.wdata;
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!o_req_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, ".ready"}, 32'(o_req_ready), 32'(1'b1));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    wait_ready(nm);
    send_req(v);
    if (v.rej) begin
      chk({nm, ".no_req"}, 32'(mem_bus.mem_req), 32'(1'b0));
      @(negedge clk);
    end else begin
      chk({nm, ".mem_req"}, 32'(mem_bus.mem_req), 32'(1'b1));
      chk({nm, ".mem_addr"}, mem_bus.mem_addr, v.e_addr);
      chk({nm, ".mem_be"}, 32'(mem_bus.mem_be), 32'(v.e_be));
      chk({nm, ".mem_we"}, 32'(mem_bus.mem_we), 32'(v.we));
      if (v.we) chk({nm, ".mem_wdata"}, mem_bus.mem_wdata, v.e_wdata);
      repeat (v.delay) @(negedge clk);
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = v.rdata;
      @(negedge clk);
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
      chk({nm, ".req_drop"}, 32'(mem_bus.mem_req), 32'(1'b0));
      chk({nm, ".early_resp"}, 32'(o_resp_valid), 32'(1'b0));
      @(negedge clk);
    end
    chk({nm, ".resp_valid"}, 32'(o_resp_valid), 32'(1'b1));
    chk({nm, ".rdata"}, o_resp_rdata, v.e_rdata);
    chk({nm, ".fault"}, 32'(o_resp_fault), 32'(v.e_fault));
    chk({nm, ".ready_b2b"}, 32'(o_req_ready), 32'(1'b1));
    @(negedge clk);
    chk({nm, ".pulse"}, 32'(o_resp_valid), 32'(1'b0));
  endtask

  vec_t vecs[12];

  initial begin
    vec_t t;
    int   hi;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;

    vecs[0]  = mk(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    vecs[2]  = mk(0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080);
    vecs[3]  = mk(1, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h0, 0, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0);
    vecs[4]  = mk(0, 2'b01, 0, 32'h200, 32'h0, 32'h12348001, 1, 32'h200, 4'b0011, 32'h0, 32'hFFFF8001);
    vecs[5]  = mk(0, 2'b01, 1, 32'h202, 32'h0, 32'h87650000, 0, 32'h200, 4'b1100, 32'h0, 32'h00008765);
    vecs[6]  = mk(1, 2'b00, 0, 32'h301, 32'h123456A5, 32'h0, 2, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0);
    vecs[7]  = mk(0, 2'b10, 0, 32'h400, 32'h0, 32'hCAFEF00D, 3, 32'h400, 4'b1111, 32'h0, 32'hCAFEF00D);
    vecs[8]  = mk(0, 2'b00, 0, 32'h101, 32'h0, 32'h00007F00, 0, 32'h100, 4'b0010, 32'h0, 32'h0000007F);
    vecs[9]  = mk(0, 2'b10, 0, 32'h101, 32'h0, 32'h11223344, 0, 32'h100, 4'b1111, 32'h0, 32'h11223344);
    vecs[10] = mk(0, 2'b01, 0, 32'h203, 32'h0, 32'hFFEE8000, 0, 32'h200, 4'b1100, 32'h0, 32'hFFFFFFEE);
    vecs[11] = mk(0, 2'b11, 0, 32'h500, 32'h0, 32'h89ABCDEF, 0, 32'h500, 4'b1111, 32'h0, 32'h89ABCDEF);
`ifdef LSU_MISALIGN_TRAP_EN
    for (int k = 9; k < 12; k++) begin
      vecs[k].rej = 1'b1; vecs[k].e_rdata = '0; vecs[k].e_fault = 1'b1;
    end
`endif

    // Reset values
    @(negedge clk);
    chk("rst.ready", 32'(o_req_ready), 32'(1'b0));
    chk("rst.mem_req", 32'(mem_bus.mem_req), 32'(1'b0));
    chk("rst.resp_valid", 32'(o_resp_valid), 32'(1'b0));
    chk("rst.resp_rdata", o_resp_rdata, 32'h0);
    chk("rst.mem_addr", mem_bus.mem_addr, 32'h0);
    chk("rst.mem_be", 32'(mem_bus.mem_be), 32'h0);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Timeout: mem_req held 4 cycles, fault response, late ack ignored
    t = mk(0, 2'b10, 0, 32'h600, 32'h0, 32'h0, 0, 32'h600, 4'b1111, 32'h0, 32'h0);
    wait_ready("to");
    send_req(t);
    hi = 0;
    for (int c = 0; c < 8 && mem_bus.mem_req; c++) begin hi++; @(negedge clk); end
    chk("to.req_cycles", 32'(hi), 32'd4);
    chk("to.req_low", 32'(mem_bus.mem_req), 32'(1'b0));
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    chk("to.resp_valid", 32'(o_resp_valid), 32'(1'b1));
    chk("to.fault", 32'(o_resp_fault), 32'(1'b1));
    chk("to.rdata", o_resp_rdata, 32'h0);
    @(negedge clk);
    chk("to.late_ack_resp", 32'(o_resp_valid), 32'(1'b0));
    chk("to.late_ack_req", 32'(mem_bus.mem_req), 32'(1'b0));
    chk("to.hold_fault", 32'(o_resp_fault), 32'(1'b1));

    // Reset during BUS: mem_req drops immediately, no response
    wait_ready("rb");
    send_req(vecs[7]);
    chk("rb.in_bus", 32'(mem_bus.mem_req), 32'(1'b1));
    reset = 1'b1;
    #1;
    chk("rb.req_async", 32'(mem_bus.mem_req), 32'(1'b0));
    @(negedge clk);
    chk("rb.ready", 32'(o_req_ready), 32'(1'b0));
    reset = 1'b0;
    hi = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_resp_valid) hi++;
      @(negedge clk);
    end
    chk("rb.no_resp", 32'(hi), 32'd0);
    run_vec(vecs[0], "rb.after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
